// File: rtl/param_seq_detector.sv
// Run-time programmable serial pattern detector with overlapping or non-overlapping matching.
// Outputs a same-cycle Mealy match, a registered copy of it and a saturating match counter.
module param_seq_detector #(
  parameter int unsigned      PAT_W   = 4,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1010),
  parameter logic             OVL_RST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned      FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } state_e;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] window;
  state_e           state;

  // The fill level is the detector state: ARMED once a full history is held.
  assign state  = (fill_q == FILL_MAX) ? ARMED : FILLING;
  assign window = {hist_q, x};
  assign z      = x_valid & ~cfg_load & ~rst & (state == ARMED) & (window == pat_q);

  assign match_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q  <= PAT_RST;
      ovl_q  <= OVL_RST;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      z_q    <= z;
    end
  end

  always_comb begin
    pat_d  = pat_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (x_valid) begin
      // A non-overlapping match consumes its bits, so detection restarts from empty.
      if (z && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        if (state == FILLING) begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (z && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// Randomised and directed bench for param_seq_detector, checked against a queue-based model.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_param_seq_detector;

  logic       clk;
  logic       rst;
  logic       xIn;
  logic       xvIn;
  logic       ldIn;
  logic [3:0] patIn;
  logic       ovlIn;
  logic       clrIn;
  logic       z, zQ, zSat, zQSat;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: valid bits seen since the last restart, plus active configuration.
  bit         mq[$];
  logic [3:0] mPat;
  bit         mOvl;
  int         mCnt8, mCnt2;
  bit         expZ, expZq;

  param_seq_detector #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x(xIn), .x_valid(xvIn), .cfg_load(ldIn),
    .cfg_pattern(patIn), .cfg_overlap(ovlIn), .cnt_clr(clrIn),
    .z(z), .z_q(zQ), .match_cnt(cnt8)
  );

  param_seq_detector #(.PAT_W(4), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .x(xIn), .x_valid(xvIn), .cfg_load(ldIn),
    .cfg_pattern(patIn), .cfg_overlap(ovlIn), .cnt_clr(clrIn),
    .z(zSat), .z_q(zQSat), .match_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] timeout");
  end

  function automatic bit modelZ();
    logic [3:0] w;
    if (!xvIn || ldIn || rst || mq.size() < 3) return 1'b0;
    w = {mq[mq.size()-3], mq[mq.size()-2], mq[mq.size()-1], xIn};
    return w == mPat;
  endfunction

  task automatic modelReset();
    mq.delete();
    mPat  = 4'b1010;
    mOvl  = 1'b1;
    mCnt8 = 0;
    mCnt2 = 0;
    expZq = 1'b0;
  endtask

  // Called just after a falling edge: apply inputs and predict the Mealy output.
  task automatic drive(input bit xi, input bit xv, input bit ld = 1'b0,
                       input logic [3:0] p = 4'b0, input bit o = 1'b0, input bit clr = 1'b0);
    xIn = xi; xvIn = xv; ldIn = ld; patIn = p; ovlIn = o; clrIn = clr;
    #1;
    expZ = modelZ();
  endtask

  task automatic tick();
    @(posedge clk);
    if (clrIn) begin
      mCnt8 = 0; mCnt2 = 0;
    end else if (expZ) begin
      mCnt8 = (mCnt8 < 255) ? mCnt8 + 1 : 255;
      mCnt2 = (mCnt2 < 3) ? mCnt2 + 1 : 3;
    end
    expZq = expZ;
    if (ldIn) begin
      mPat = patIn; mOvl = ovlIn; mq.delete();
    end else if (xvIn) begin
      if (expZ && !mOvl) mq.delete();
      else begin
        mq.push_back(xIn);
        if (mq.size() > 8) void'(mq.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    nCompared++;
    if (z !== 1'b0 || zQ !== 1'b0 || cnt8 !== 8'd0) begin
      nMismatched++;
      $display("FAIL reset_outputs: got z=%b z_q=%b cnt=%0d, required 0/0/0", z, zQ, cnt8);
    end
    rst = 1'b0;
    modelReset();
    drive(1'b0, 1'b0);
    tick();
    nCompared++;
    if (zQ !== 1'b0 || cnt2 !== 2'd0) begin
      nMismatched++;
      $display("FAIL reset_release: got z_q=%b cnt2=%0d, required 0/0", zQ, cnt2);
    end
  endtask

  task automatic test_stream(input bit ovl, input logic [14:0] hitMask, input int expCnt);
    logic [14:0] stream;
    stream = 15'b110101011101010;
    drive(1'b0, 1'b0, 1'b1, 4'b1010, ovl, 1'b1);
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(stream[14-i], 1'b1);
      nCompared++;
      if (z !== expZ || z !== hitMask[i]) begin
        nMismatched++;
        $display("FAIL stream_ovl%0d_z[%0d]: got %b, required %b", ovl, i, z, hitMask[i]);
      end
      tick();
      nCompared++;
      if (zQ !== hitMask[i]) begin
        nMismatched++;
        $display("FAIL stream_ovl%0d_zq[%0d]: got %b, required %b", ovl, i, zQ, hitMask[i]);
      end
    end
    nCompared++;
    if (cnt8 !== 8'(expCnt)) begin
      nMismatched++;
      $display("FAIL stream_ovl%0d_cnt: got %0d, required %0d", ovl, cnt8, expCnt);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] bits;
    bits = 4'b1010;
    for (int g = 0; g < 2; g++) begin
      drive(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b1);
      tick();
      for (int k = 0; k < 4; k++) begin
        drive(bits[3-k], 1'b1);
        nCompared++;
        if (z !== expZ || z !== (k == 3)) begin
          nMismatched++;
          $display("FAIL gaps%0d_z[%0d]: got %b, required %b", g, k, z, (k == 3));
        end
        tick();
        if (k < 3) begin
          for (int c = 0; c < 3; c++) begin
            drive(g[0], 1'b0);
            nCompared++;
            if (z !== 1'b0) begin
              nMismatched++;
              $display("FAIL gaps%0d_idle_z: got %b, required 0", g, z);
            end
            tick();
          end
        end
      end
      nCompared++;
      if (cnt8 !== 8'd1) begin
        nMismatched++;
        $display("FAIL gaps%0d_cnt: got %0d, required 1", g, cnt8);
      end
    end
  endtask

  task automatic test_reprogram();
    logic [5:0] tail;
    tail = 6'b011010;
    drive(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1); tick();
    drive(1'b0, 1'b1); tick();
    drive(1'b1, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
    nCompared++;
    if (z !== 1'b0) begin
      nMismatched++;
      $display("FAIL reprog_load_z: got %b, required 0", z);
    end
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(tail[5-k], 1'b1);
      nCompared++;
      if (z !== expZ || z !== (k == 3)) begin
        nMismatched++;
        $display("FAIL reprog_z[%0d]: got %b, required %b", k, z, (k == 3));
      end
      tick();
    end
    nCompared++;
    if (cnt8 !== 8'd1) begin
      nMismatched++;
      $display("FAIL reprog_cnt: got %0d, required 1", cnt8);
    end
  endtask

  task automatic test_saturation();
    int satExp[10] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 3};
    drive(1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(((i % 2) == 0), 1'b1);
      tick();
      nCompared++;
      if (cnt2 !== 2'(satExp[i]) || cnt2 !== 2'(mCnt2)) begin
        nMismatched++;
        $display("FAIL sat_cnt[%0d]: got %0d, required %0d", i, cnt2, satExp[i]);
      end
    end
    drive(1'b1, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
    nCompared++;
    if (z !== 1'b1) begin
      nMismatched++;
      $display("FAIL clr_match_z: got %b, required 1", z);
    end
    tick();
    nCompared++;
    if (cnt2 !== 2'd0 || cnt8 !== 8'd0) begin
      nMismatched++;
      $display("FAIL clr_with_match: got cnt2=%0d cnt8=%0d, required 0/0", cnt2, cnt8);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] pre;
    logic [4:0] post;
    pre  = 5'b11001;
    post = 5'b01010;
    drive(1'b0, 1'b0, 1'b1, 4'b1100, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(pre[4-k], 1'b1); tick();
    end
    drive(pre[0], 1'b1);
    nCompared++;
    if (zQ !== 1'b1 || cnt8 !== 8'd1) begin
      nMismatched++;
      $display("FAIL arst_pre: got z_q=%b cnt=%0d, required 1/1", zQ, cnt8);
    end
    #2 rst = 1'b1;
    #1;
    nCompared++;
    if (z !== 1'b0 || zQ !== 1'b0 || cnt8 !== 8'd0) begin
      nMismatched++;
      $display("FAIL arst_immediate: got z=%b z_q=%b cnt=%0d, required 0/0/0", z, zQ, cnt8);
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int k = 0; k < 5; k++) begin
      drive(post[4-k], 1'b1);
      nCompared++;
      if (z !== expZ || z !== (k == 4)) begin
        nMismatched++;
        $display("FAIL arst_post_z[%0d]: got %b, required %b", k, z, (k == 4));
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(1, 0), ($urandom % 4) != 0, ($urandom % 20) == 0,
            4'($urandom), $urandom_range(1, 0), ($urandom % 25) == 0);
      nCompared++;
      if (z !== expZ || zSat !== expZ) begin
        nMismatched++;
        $display("FAIL rand_z[%0d]: got %b/%b, required %b", i, z, zSat, expZ);
      end
      tick();
      nCompared++;
      if (zQ !== expZq || zQSat !== expZq || cnt8 !== 8'(mCnt8) || cnt2 !== 2'(mCnt2)) begin
        nMismatched++;
        $display("FAIL rand_regs[%0d]: got z_q=%b/%b cnt=%0d/%0d, required %b cnt=%0d/%0d",
                 i, zQ, zQSat, cnt8, cnt2, expZq, mCnt8, mCnt2);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    xIn = 1'b0; xvIn = 1'b0; ldIn = 1'b0; patIn = 4'b0; ovlIn = 1'b0; clrIn = 1'b0;
    modelReset();
    @(negedge clk);
    test_reset();
    test_stream(1'b1, 15'b101000001010000, 4);
    test_stream(1'b0, 15'b001000000010000, 2);
    test_gaps();
    test_reprogram();
    test_saturation();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
